// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a 4:1 mux: walks the masked channels in ascending order, dwells DWELL cycles on
// each, and assembles the sampled mux output into a 4-bit snapshot. Optional build: MUX_SCAN_MAJORITY_EN.
module mux_scan_sequencer #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] channel_mask,
  input  logic       mux_out,
  output logic [1:0] select_lines,
  output logic [3:0] sample,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DWELL  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0] state;
  logic [3:0] mask_q;
  logic [7:0] cnt;
  logic       last_cyc;
  logic       have_next;
  logic [1:0] next_ch;
  logic [1:0] first_ch;
  logic       bit_val;

  assign last_cyc = (cnt == 8'(DWELL - 1));

  // Descending loops so the final hit is the lowest qualifying channel.
  always_comb begin
    have_next = 1'b0;
    next_ch   = select_lines;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(select_lines))) begin
        have_next = 1'b1;
        next_ch   = 2'(i);
      end
    end
  end

  always_comb begin
    first_ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (channel_mask[i]) first_ch = 2'(i);
    end
  end

`ifdef MUX_SCAN_MAJORITY_EN
  localparam int OW = $clog2(DWELL + 1);

  logic [OW-1:0] ones;
  logic [OW:0]   ones_nxt;

  // Include the current cycle's mux_out so the decision covers all DWELL cycles; ties resolve to 0.
  assign ones_nxt = {1'b0, ones} + (OW+1)'(mux_out);
  assign bit_val  = ({ones_nxt, 1'b0} > (OW+2)'(DWELL));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ones <= '0;
    end else if (state == S_DWELL) begin
      ones <= last_cyc ? '0 : ones_nxt[OW-1:0];
    end else begin
      ones <= '0;
    end
  end
`else
  assign bit_val = mux_out;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      mask_q       <= 4'b0000;
      cnt          <= 8'd0;
      select_lines <= 2'b00;
      sample       <= 4'b0000;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mask_q <= channel_mask;
            sample <= 4'b0000;
            cnt    <= 8'd0;
            if (|channel_mask) begin
              state        <= S_DWELL;
              select_lines <= first_ch;
              busy         <= 1'b1;
            end else begin
              state <= S_FINISH;
              done  <= 1'b1;
            end
          end
        end
        S_DWELL: begin
          if (last_cyc) begin
            sample[select_lines] <= bit_val;
            cnt                  <= 8'd0;
            if (have_next) begin
              select_lines <= next_ch;
            end else begin
              state <= S_FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Randomized bench for mux_scan_sequencer: a behavioural 4:1 mux plus per-scan reference model of the
// expected select sequence, handshake timing and sample snapshot.
module tb_mux_scan_sequencer;
  localparam int DW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] channel_mask = 4'b0000;
  logic       mux_out;
  logic [1:0] select_lines;
  logic [3:0] sample;
  logic       busy;
  logic       done;

  logic [3:0] mux_in = 4'b0000;
  logic       flip = 1'b0;
  logic [1:0] exp_sel = 2'b00;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  // Downstream mux, purely combinational; flip injects per-cycle noise/glitches.
  assign mux_out = mux_in[select_lines] ^ flip;

  mux_scan_sequencer #(.DWELL(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .channel_mask(channel_mask),
    .mux_out(mux_out), .select_lines(select_lines), .sample(sample),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // fmode: 0 clean, 1 random flips every cycle, 2 glitch on last dwell cycle of channel 2.
  // noise: hold start high and scramble channel_mask throughout the scan.
  // hold: leave start high through the done cycle so the next scan is re-accepted from IDLE.
  task automatic run_scan(input logic [3:0] m, input logic [3:0] ins, input int fmode,
                          input bit noise, input bit hold);
    int         chs[$];
    int         ones[4];
    logic [3:0] exp_s;
    int         n;
    exp_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      ones[i] = 0;
      if (m[i]) chs.push_back(i);
    end
    n = chs.size();
    channel_mask = m;
    mux_in       = ins;
    start        = 1'b1;
    cyc();
    start = 1'b0;
    for (int t = 0; t < n * DW; t++) begin
      int   ch;
      int   ph;
      logic v;
      ch = chs[t / DW];
      ph = t % DW;
      chk("sel", select_lines, ch);
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      if (noise) begin
        start        = 1'b1;
        channel_mask = 4'($urandom);
      end
      case (fmode)
        1:       flip = 1'($urandom);
        2:       flip = (ch == 2) && (ph == DW - 1);
        default: flip = 1'b0;
      endcase
      v = ins[ch] ^ flip;
      ones[ch] += int'(v);
`ifdef MUX_SCAN_MAJORITY_EN
      if (ph == DW - 1) exp_s[ch] = (2 * ones[ch] > DW);
`else
      if (ph == DW - 1) exp_s[ch] = v;
`endif
      cyc();
    end
    flip = 1'b0;
    if (n > 0) exp_sel = 2'(chs[n-1]);
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 0);
    chk("sample", sample, exp_s);
    chk("sel_hold", select_lines, exp_sel);
    start        = hold;
    channel_mask = 4'($urandom);
    cyc();
    chk("done_clear", done, 0);
    chk("busy_idle", busy, 0);
    chk("sample_keep", sample, exp_s);
    chk("sel_idle", select_lines, exp_sel);
  endtask

  task automatic reset_mid();
    channel_mask = 4'hF;
    mux_in       = 4'hF;
    start        = 1'b1;
    cyc();
    start = 1'b0;
    repeat (5) cyc();
    rst_n = 1'b0;
    cyc();
    chk("rst_sel", select_lines, 0);
    chk("rst_sample", sample, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n   = 1'b1;
    exp_sel = 2'b00;
    repeat (20) begin
      cyc();
      chk("no_done_after_rst", done, 0);
      chk("no_busy_after_rst", busy, 0);
    end
  endtask

  initial begin
    @(negedge clk);
    cyc();
    chk("reset_sel", select_lines, 0);
    chk("reset_sample", sample, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst_n = 1'b1;
    cyc();

    run_scan(4'b1111, 4'b0101, 0, 1'b0, 1'b0);
    run_scan(4'b1010, 4'b1111, 0, 1'b0, 1'b0);
    run_scan(4'b0000, 4'b0011, 0, 1'b0, 1'b0);
    run_scan(4'b1111, 4'b1001, 0, 1'b1, 1'b1);
    run_scan(4'b0110, 4'b0100, 0, 1'b0, 1'b0);
    reset_mid();
    run_scan(4'b0000, 4'b1111, 0, 1'b0, 1'b0);
    run_scan(4'b1111, 4'b0000, 2, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      run_scan(4'($urandom), 4'($urandom), int'($urandom_range(0, 2)),
               1'($urandom), 1'($urandom));
    end
    start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
